// File: rtl/uart_pkg.sv
// Shared types and constants for the word-assembling UART receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } rx_state_e;

  localparam int DATA_BITS      = 8;
  localparam int BYTES_PER_WORD = 4;
  localparam int TIMEOUT_MULT   = 16;

  localparam logic [15:0] DEF_DIV = 16'd1;

endpackage

// File: rtl/uart_rx_baud_cnt.sv
// Free-running cycle counter giving half-bit and full-bit ticks.
module uart_rx_baud_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        restart,
  input  logic [15:0] div,
  output logic        half_tick,
  output logic        full_tick
);

  logic [16:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 17'd1;
    if (restart) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign half_tick = (cnt_q == ({1'b0, div} - 17'd1));
  assign full_tick = (cnt_q == ({div, 1'b0} - 17'd1));

endmodule

// File: rtl/uart_rx_word.sv
// 8N1 UART receiver packing four bytes into a 32-bit word.
// Define UART_RX_TIMEOUT_EN for the inter-byte timeout and timeout_err.
module uart_rx_word
  import uart_pkg::*;
#(
  parameter logic [15:0] DEFAULT_DIV = DEF_DIV
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        div_en,
  input  logic [15:0] div_in,
  input  logic        ser_rx,
  input  logic        rx_ack,
  output logic [31:0] d_out,
  output logic        rx_ready,
  output logic        frame_err,
`ifdef UART_RX_TIMEOUT_EN
  output logic        overrun,
  output logic        timeout_err
`else
  output logic        overrun
`endif
);

  logic        rx_s1_q, rx_s2_q, rx_p_q;
  logic        den_q, en_q, en_d;
  logic [15:0] div_q, div_d;
  rx_state_e   state_q, state_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  sh_q, sh_d;
  logic [1:0]  bcnt_q, bcnt_d;
  logic [23:0] word_q, word_d;
  logic [31:0] dout_q, dout_d;
  logic        rdy_q, rdy_d;
  logic        ferr_q, ferr_d;
  logic        ovr_q, ovr_d;
  logic        wait_q, wait_d;
  logic        restart, half_tick, full_tick;
  logic        done, to_fire, rx_s, fall;

  assign rx_s = rx_s2_q;
  assign fall = rx_p_q & ~rx_s;

  uart_rx_baud_cnt u_baud (
    .clk       (clk),
    .rst       (rst),
    .restart   (restart),
    .div       (div_q),
    .half_tick (half_tick),
    .full_tick (full_tick)
  );

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    bcnt_d  = bcnt_q;
    word_d  = word_q;
    dout_d  = dout_q;
    rdy_d   = rdy_q;
    ferr_d  = ferr_q;
    ovr_d   = ovr_q;
    wait_d  = wait_q;
    restart = 1'b0;
    done    = 1'b0;
    en_d    = en_q | (den_q & ~div_en);
    div_d   = div_q;
    if (div_en) div_d = (div_in < 16'd2) ? DEFAULT_DIV : div_in;

    if (rx_ack && rdy_q) begin
      rdy_d  = 1'b0;
      ferr_d = 1'b0;
      ovr_d  = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        restart = 1'b1;
        if (en_q && fall) state_d = S_START;
      end
      S_START: begin
        if (half_tick) begin
          restart = 1'b1;
          bit_d   = '0;
          state_d = rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (full_tick) begin
          restart = 1'b1;
          sh_d    = {rx_s, sh_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'(DATA_BITS - 1)) state_d = S_STOP;
        end
      end
      S_STOP: begin
        // after a framing error, hold here until the line idles high
        if (wait_q) begin
          restart = 1'b1;
          if (rx_s) begin
            wait_d  = 1'b0;
            state_d = S_IDLE;
          end
        end else if (full_tick) begin
          restart = 1'b1;
          if (rx_s) begin
            state_d = S_IDLE;
            bcnt_d  = bcnt_q + 2'd1;
            unique case (bcnt_q)
              2'd0: word_d[7:0]   = sh_q;
              2'd1: word_d[15:8]  = sh_q;
              2'd2: word_d[23:16] = sh_q;
              default: done = 1'b1;
            endcase
          end else begin
            ferr_d = 1'b1;
            bcnt_d = '0;
            wait_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (done) begin
      if (!rdy_q || rx_ack) begin
        dout_d = {sh_q, word_q};
        rdy_d  = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end

    if (to_fire) bcnt_d = '0;

    if (div_en) begin
      state_d = S_IDLE;
      bcnt_d  = '0;
      wait_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      rx_p_q  <= 1'b1;
      den_q   <= 1'b0;
      en_q    <= 1'b0;
      div_q   <= DEFAULT_DIV;
      state_q <= S_IDLE;
      bit_q   <= '0;
      sh_q    <= '0;
      bcnt_q  <= '0;
      word_q  <= '0;
      dout_q  <= '0;
      rdy_q   <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      wait_q  <= 1'b0;
    end else begin
      rx_s1_q <= ser_rx;
      rx_s2_q <= rx_s1_q;
      rx_p_q  <= rx_s2_q;
      den_q   <= div_en;
      en_q    <= en_d;
      div_q   <= div_d;
      state_q <= state_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      bcnt_q  <= bcnt_d;
      word_q  <= word_d;
      dout_q  <= dout_d;
      rdy_q   <= rdy_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
      wait_q  <= wait_d;
    end
  end

`ifdef UART_RX_TIMEOUT_EN
  logic [21:0] to_cnt_q, to_cnt_d, to_lim;
  logic        to_err_q;

  assign to_lim = 22'(div_q) * 22'(2 * TIMEOUT_MULT);

  always_comb begin
    to_cnt_d = '0;
    to_fire  = 1'b0;
    if (state_q == S_IDLE && bcnt_q != 2'd0 && en_q && !div_en) begin
      if (to_cnt_q == to_lim) to_fire = 1'b1;
      else                    to_cnt_d = to_cnt_q + 22'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt_q <= '0;
      to_err_q <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      to_err_q <= to_fire;
    end
  end

  assign timeout_err = to_err_q;
`else
  assign to_fire = 1'b0;
`endif

  assign d_out     = dout_q;
  assign rx_ready  = rdy_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx_word.sv
// Randomized self-checking bench for uart_rx_word with a word-level model.
module tb_uart_rx_word;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        div_en = 1'b0;
  logic [15:0] div_in = 16'd0;
  logic        ser_rx = 1'b1;
  logic        rx_ack = 1'b0;
  logic [31:0] d_out;
  logic        rx_ready, frame_err, overrun;
`ifdef UART_RX_TIMEOUT_EN
  logic        timeout_err;
  int          to_pulses = 0;
`endif

  int total = 0, bad = 0;
  int cyc = 0, rise_cyc = 0;
  int cur_div = 3, last_start = 0, bytes_started = 0;
  logic rdy_prev = 1'b0;

  logic [7:0]  m_q[$];
  logic [31:0] m_dout = '0;
  logic        m_rdy = 1'b0, m_ferr = 1'b0, m_ovr = 1'b0;

  uart_rx_word #(.DEFAULT_DIV(16'd3)) dut (
    .clk       (clk),
    .rst       (rst),
    .div_en    (div_en),
    .div_in    (div_in),
    .ser_rx    (ser_rx),
    .rx_ack    (rx_ack),
    .d_out     (d_out),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
`ifdef UART_RX_TIMEOUT_EN
    .overrun     (overrun),
    .timeout_err (timeout_err)
`else
    .overrun   (overrun)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_ready && !rdy_prev) rise_cyc <= cyc;
    rdy_prev <= rx_ready;
  end

`ifdef UART_RX_TIMEOUT_EN
  always @(negedge clk) if (timeout_err) to_pulses <= to_pulses + 1;
`endif

  task automatic model_byte(input logic [7:0] b, input logic ok);
    logic [31:0] w;
    if (!ok) begin
      m_ferr = 1'b1;
      m_q.delete();
    end else begin
      m_q.push_back(b);
      if (m_q.size() == 4) begin
        w = {m_q[3], m_q[2], m_q[1], m_q[0]};
        m_q.delete();
        if (m_rdy) m_ovr = 1'b1;
        else begin
          m_dout = w;
          m_rdy  = 1'b1;
        end
      end
    end
  endtask

  task automatic model_ack();
    if (m_rdy) begin
      m_rdy  = 1'b0;
      m_ferr = 1'b0;
      m_ovr  = 1'b0;
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_dout = '0;
    m_rdy  = 1'b0;
    m_ferr = 1'b0;
    m_ovr  = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    ser_rx = b;
    repeat (2 * cur_div) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    last_start = cyc;
    bytes_started++;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
    model_byte(b, stop);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int k = 0; k < 4; k++) begin
      send_byte(w[8*k +: 8], 1'b1);
      repeat (gap) @(negedge clk);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic configure(input int d);
    div_in = 16'(d);
    div_en = 1'b1;
    @(negedge clk);
    div_en = 1'b0;
    div_in = 16'($urandom);
    repeat (2) @(negedge clk);
    cur_div = (d < 2) ? 3 : d;
    m_q.delete();
  endtask

  task automatic do_ack();
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
    model_ack();
    @(negedge clk);
  endtask

  task automatic test_reset();
    total++; if (d_out !== 32'h0) begin bad++; $display("FAIL rst_dout: got %h want 0", d_out); end
    total++; if (rx_ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b want 0", rx_ready); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL rst_ferr: got %b want 0", frame_err); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL rst_ovr: got %b want 0", overrun); end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    // receiver is not yet enabled, so a full word must be ignored
    for (int k = 0; k < 4; k++) send_byte(8'(k + 8'h40), 1'b1);
    repeat (4) @(negedge clk);
    model_reset();
    total++; if (rx_ready !== 1'b0) begin bad++; $display("FAIL disabled_ready: got %b want 0", rx_ready); end
  endtask

  task automatic test_deadbeef();
    configure(4);
    send_word(32'hDEADBEEF, 0);
    total++; if (d_out !== m_dout) begin bad++; $display("FAIL word_dout: got %h want %h", d_out, m_dout); end
    total++; if (rx_ready !== m_rdy) begin bad++; $display("FAIL word_ready: got %b want %b", rx_ready, m_rdy); end
    total++; if (rise_cyc - last_start !== 19 * cur_div + 3) begin
      bad++; $display("FAIL ready_latency: got %0d want %0d", rise_cyc - last_start, 19 * cur_div + 3);
    end
    do_ack();
    total++; if (rx_ready !== 1'b0) begin bad++; $display("FAIL ack_ready: got %b want 0", rx_ready); end
  endtask

  task automatic test_glitch();
    logic [31:0] w;
    w = $urandom;
    send_byte(w[7:0], 1'b1);
    ser_rx = 1'b0;
    repeat (3) @(negedge clk);
    ser_rx = 1'b1;
    repeat (16 * cur_div) @(negedge clk);
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL glitch_ferr: got %b want 0", frame_err); end
    for (int k = 1; k < 4; k++) send_byte(w[8*k +: 8], 1'b1);
    repeat (4) @(negedge clk);
    total++; if (d_out !== m_dout || rx_ready !== m_rdy) begin
      bad++; $display("FAIL glitch_word: got %h/%b want %h/%b", d_out, rx_ready, m_dout, m_rdy);
    end
    do_ack();
  endtask

  task automatic test_frame_err();
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b0);
    ser_rx = 1'b1;
    repeat (8 * cur_div) @(negedge clk);
    total++; if (frame_err !== m_ferr) begin bad++; $display("FAIL ferr_set: got %b want %b", frame_err, m_ferr); end
    do_ack();
    total++; if (frame_err !== m_ferr) begin bad++; $display("FAIL ferr_idle_ack: got %b want %b", frame_err, m_ferr); end
    send_word(32'h01020304, 0);
    total++; if (d_out !== m_dout || rx_ready !== m_rdy) begin
      bad++; $display("FAIL ferr_word: got %h/%b want %h/%b", d_out, rx_ready, m_dout, m_rdy);
    end
    do_ack();
    total++; if (frame_err !== 1'b0 || rx_ready !== 1'b0) begin
      bad++; $display("FAIL ferr_clear: got %b/%b want 0/0", frame_err, rx_ready);
    end
  endtask

  task automatic test_overrun();
    logic [31:0] wa, wb;
    wa = $urandom;
    wb = $urandom;
    send_word(wa, $urandom_range(0, 3));
    send_word(wb, $urandom_range(0, 3));
    total++; if (overrun !== m_ovr) begin bad++; $display("FAIL ovr_set: got %b want %b", overrun, m_ovr); end
    total++; if (d_out !== m_dout) begin bad++; $display("FAIL ovr_keep: got %h want %h", d_out, m_dout); end
    do_ack();
    total++; if (overrun !== 1'b0 || rx_ready !== 1'b0 || frame_err !== 1'b0) begin
      bad++; $display("FAIL ovr_ack: got %b/%b/%b want 0/0/0", overrun, rx_ready, frame_err);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] wa, wb;
    int bs0;
    wa = $urandom;
    wb = $urandom;
    send_word(wa, 0);
    bs0 = bytes_started;
    fork
      send_word(wb, 0);
      begin
        int n = 0;
        while (!(bytes_started == bs0 + 4 && cyc == last_start + 19 * cur_div + 2) && n < 5000) begin
          @(negedge clk);
          n++;
        end
        total++;
        if (n >= 5000) begin
          bad++; $display("FAIL ack_window: got timeout want completion cycle");
        end else begin
          rx_ack = 1'b1;
          model_ack();
          @(negedge clk);
          rx_ack = 1'b0;
        end
      end
    join
    total++; if (d_out !== m_dout || rx_ready !== m_rdy) begin
      bad++; $display("FAIL same_cycle: got %h/%b want %h/%b", d_out, rx_ready, m_dout, m_rdy);
    end
    total++; if (overrun !== m_ovr) begin bad++; $display("FAIL same_ovr: got %b want %b", overrun, m_ovr); end
    do_ack();
  endtask

  task automatic test_random();
    logic [31:0] w;
    for (int it = 0; it < 5; it++) begin
      configure($urandom_range(0, 7));
      w = $urandom;
      send_word(w, $urandom_range(0, 2 * cur_div));
      total++; if (d_out !== m_dout || rx_ready !== m_rdy) begin
        bad++; $display("FAIL rand_word%0d: got %h/%b want %h/%b", it, d_out, rx_ready, m_dout, m_rdy);
      end
      do_ack();
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    configure(4);
    send_word($urandom, 0);
    send_byte($urandom, 1'b1);
    b = $urandom;
    ser_rx = 1'b0;
    repeat (2 * cur_div) @(negedge clk);
    for (int i = 0; i < 5; i++) send_bit(b[i]);
    ser_rx = b[5];
    repeat (cur_div) @(negedge clk);
    rst = 1'b0;
    #1;
    model_reset();
    total++; if (d_out !== m_dout || rx_ready !== m_rdy || frame_err !== m_ferr || overrun !== m_ovr) begin
      bad++; $display("FAIL mid_rst: got %h/%b/%b/%b want 0", d_out, rx_ready, frame_err, overrun);
    end
    ser_rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    configure(5);
    send_word($urandom, 1);
    total++; if (d_out !== m_dout || rx_ready !== m_rdy) begin
      bad++; $display("FAIL post_rst_word: got %h/%b want %h/%b", d_out, rx_ready, m_dout, m_rdy);
    end
    do_ack();
  endtask

`ifdef UART_RX_TIMEOUT_EN
  task automatic test_timeout();
    int base;
    configure(3);
    base = to_pulses;
    send_byte($urandom, 1'b1);
    send_byte($urandom, 1'b1);
    repeat (80 * cur_div) @(negedge clk);
    m_q.delete();
    total++; if (to_pulses - base !== 1) begin
      bad++; $display("FAIL timeout_pulse: got %0d want 1", to_pulses - base);
    end
    send_word($urandom, 0);
    total++; if (d_out !== m_dout || rx_ready !== m_rdy) begin
      bad++; $display("FAIL timeout_word: got %h/%b want %h/%b", d_out, rx_ready, m_dout, m_rdy);
    end
    do_ack();
  endtask
`endif

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    test_deadbeef();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_back_to_back();
    test_random();
    test_reset_mid();
`ifdef UART_RX_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
